// File: rtl/ps2_kbd_cmd_sequencer_if.sv
// ----------------------------------------------------------------------------
// ps2_kbd_cmd_sequencer_if
// Bundles the signals between the PS/2 command sequencer, the byte-level PHY
// and the scan-code consumer.
//   tx_data/tx_start      -> PHY serializer (byte plus one-cycle start pulse)
//   tx_ready/tx_done      <- PHY serializer status (idle / byte clocked in)
//   rx_data/rx_valid      <- PHY deserializer (byte plus one-cycle strobe)
//   led_req/led_val       <- LED update request, {caps, num, scroll}
//   scan_data/scan_valid  -> forwarded scan code to the consumer
//   kbd_ready/busy/init_fail -> controller status
// master: the sequencer.  slave: the PHY / consumer side.
// ----------------------------------------------------------------------------
interface ps2_kbd_cmd_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       led_req;
  logic [2:0] led_val;
  logic [7:0] scan_data;
  logic       scan_valid;
  logic       kbd_ready;
  logic       busy;
  logic       init_fail;

  modport master (
    output tx_data, tx_start, scan_data, scan_valid, kbd_ready, busy, init_fail,
    input  tx_ready, tx_done, rx_data, rx_valid, led_req, led_val
  );

  modport slave (
    input  tx_data, tx_start, scan_data, scan_valid, kbd_ready, busy, init_fail,
    output tx_ready, tx_done, rx_data, rx_valid, led_req, led_val
  );
endinterface

// File: rtl/ps2_kbd_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// ps2_kbd_cmd_sequencer
// Host-side PS/2 keyboard command controller. After reset it sends 0xFF,
// waits for the ACK and the BAT result (0xAA), then idles and forwards scan
// codes. LED updates send 0xED followed by {5'b0, led_val}. Every command byte
// is ACK-checked with resend/timeout retries; exhaustion or a failed BAT lands
// in a sticky FAIL state left only through reset.
// Ports:
//   CLK100MHz  system clock
//   reset      synchronous, active-high
//   kbd        ps2_kbd_cmd_sequencer_if.master (PHY, LED request, scan output,
//              status flags)
// ----------------------------------------------------------------------------
module ps2_kbd_cmd_sequencer #(
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int BAT_TIMEOUT = 100_000_000,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 27
) (
  input  logic                           CLK100MHz,
  input  logic                           reset,
  ps2_kbd_cmd_sequencer_if.master        kbd
);

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_RESEND  = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;
  localparam logic [7:0] RSP_BAT_ERR = 8'hFC;
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BAT_LAST = CNT_W'(BAT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    SEND_RST, WAIT_ACK_RST, WAIT_BAT, IDLE,
    SEND_ED, WAIT_ACK_ED, SEND_LED, WAIT_ACK_LED, FAIL
  } state_t;

  state_t           r_state;
  logic             r_sent;       // tx_start already issued for this SEND_x visit
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retry;
  logic             r_pending;
  logic [2:0]       r_pend_val;   // latest request made while busy
  logic [2:0]       r_led_val;    // value of the update in flight
  logic [7:0]       r_tx_data;
  logic             r_tx_start;
  logic [7:0]       r_scan_data;
  logic             r_scan_valid;
  logic             r_kbd_ready;
  logic             r_busy;
  logic             r_init_fail;

  logic       w_rx_ack;
  logic       w_rx_resend;
  logic       w_retry_last;
  logic       w_pend_any;
  logic [2:0] w_pend_val;
  logic [7:0] w_send_byte;
  state_t     w_wait_state;
  state_t     w_resend_state;
  state_t     w_ack_state;

  always_comb begin
    w_rx_ack     = kbd.rx_valid && (kbd.rx_data == RSP_ACK);
    w_rx_resend  = kbd.rx_valid && (kbd.rx_data == RSP_RESEND);
    w_retry_last = ({1'b0, r_retry} + 3'd1) >= 3'(MAX_RETRY);
    // A request arriving in the very cycle we return to IDLE counts as pending.
    w_pend_any   = r_pending | kbd.led_req;
    w_pend_val   = kbd.led_req ? kbd.led_val : r_pend_val;

    w_send_byte    = 8'h00;
    w_wait_state   = r_state;
    w_resend_state = r_state;
    w_ack_state    = r_state;
    case (r_state)
      SEND_RST:     begin w_send_byte = CMD_RESET;           w_wait_state = WAIT_ACK_RST; end
      SEND_ED:      begin w_send_byte = CMD_SET_LED;         w_wait_state = WAIT_ACK_ED;  end
      SEND_LED:     begin w_send_byte = {5'b0, r_led_val};   w_wait_state = WAIT_ACK_LED; end
      WAIT_ACK_RST: begin w_resend_state = SEND_RST; w_ack_state = WAIT_BAT; end
      WAIT_ACK_ED:  begin w_resend_state = SEND_ED;  w_ack_state = SEND_LED; end
      WAIT_ACK_LED: begin w_resend_state = SEND_LED; w_ack_state = IDLE;     end
      default:      ;
    endcase
  end

  always_ff @(posedge CLK100MHz) begin
    if (reset) begin
      r_state      <= SEND_RST;
      r_sent       <= 1'b0;
      r_cnt        <= '0;
      r_retry      <= 2'd0;
      r_pending    <= 1'b0;
      r_pend_val   <= 3'd0;
      r_led_val    <= 3'd0;
      r_tx_data    <= 8'h00;
      r_tx_start   <= 1'b0;
      r_scan_data  <= 8'h00;
      r_scan_valid <= 1'b0;
      r_kbd_ready  <= 1'b0;
      r_busy       <= 1'b1;
      r_init_fail  <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_scan_valid <= 1'b0;
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;

      if (kbd.led_req && (r_state != IDLE) && (r_state != FAIL)) begin
        r_pending  <= 1'b1;
        r_pend_val <= kbd.led_val;
      end

      case (r_state)
        SEND_RST, SEND_ED, SEND_LED: begin
          if (!r_sent) begin
            if (kbd.tx_ready) begin
              r_tx_start <= 1'b1;
              r_tx_data  <= w_send_byte;
              r_sent     <= 1'b1;
            end
          end else if (kbd.tx_done) begin
            r_sent  <= 1'b0;
            r_cnt   <= '0;
            r_state <= w_wait_state;
          end
        end

        WAIT_ACK_RST, WAIT_ACK_ED, WAIT_ACK_LED: begin
          if (w_rx_ack) begin
            r_retry <= 2'd0;
            r_cnt   <= '0;
            if ((w_ack_state == IDLE) && w_pend_any) begin
              // Chain straight into the queued update; IDLE is never visible.
              r_pending <= 1'b0;
              r_led_val <= w_pend_val;
              r_state   <= SEND_ED;
            end else if (w_ack_state == IDLE) begin
              r_state     <= IDLE;
              r_kbd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state <= w_ack_state;
            end
          end else if (w_rx_resend || (r_cnt == ACK_LAST)) begin
            r_cnt <= '0;
            if (w_retry_last) begin
              r_state     <= FAIL;
              r_init_fail <= 1'b1;
              r_busy      <= 1'b0;
              r_kbd_ready <= 1'b0;
            end else begin
              r_retry <= r_retry + 2'd1;
              r_state <= w_resend_state;
            end
          end
        end

        WAIT_BAT: begin
          if (kbd.rx_valid && (kbd.rx_data == RSP_BAT_OK)) begin
            r_cnt <= '0;
            if (w_pend_any) begin
              r_pending <= 1'b0;
              r_led_val <= w_pend_val;
              r_state   <= SEND_ED;
            end else begin
              r_state     <= IDLE;
              r_kbd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end
          end else if ((kbd.rx_valid && (kbd.rx_data == RSP_BAT_ERR)) || (r_cnt == BAT_LAST)) begin
            r_cnt       <= '0;
            r_state     <= FAIL;
            r_init_fail <= 1'b1;
            r_busy      <= 1'b0;
            r_kbd_ready <= 1'b0;
          end
        end

        IDLE: begin
          if (kbd.rx_valid) begin
            r_scan_data  <= kbd.rx_data;
            r_scan_valid <= 1'b1;
          end
          if (kbd.led_req) begin
            r_led_val   <= kbd.led_val;
            r_cnt       <= '0;
            r_state     <= SEND_ED;
            r_kbd_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end

        FAIL: ;

        default: begin
          r_state     <= FAIL;
          r_init_fail <= 1'b1;
          r_busy      <= 1'b0;
          r_kbd_ready <= 1'b0;
        end
      endcase
    end
  end

  assign kbd.tx_data    = r_tx_data;
  assign kbd.tx_start   = r_tx_start;
  assign kbd.scan_data  = r_scan_data;
  assign kbd.scan_valid = r_scan_valid;
  assign kbd.kbd_ready  = r_kbd_ready;
  assign kbd.busy       = r_busy;
  assign kbd.init_fail  = r_init_fail;

endmodule
